arp_tx: RTL

ARP_TX -- requirements
Module: arp_tx

---
 rtl/arp_tx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/arp_tx.sv
// ARP request/reply frame generator driving a GMII transmit port.
// Emits preamble, Ethernet header, ARP payload, zero pad and CRC-32 FCS, then an inter-frame gap.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int unsigned CNT_W =
    ($clog2(IFG_CYCLES + 1) > 5) ? $clog2(IFG_CYCLES + 1) : 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ETH_HEAD,
    S_ARP_DATA,
    S_PAD,
    S_CRC,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               type_q, type_d;
  logic [47:0]        mac_q, mac_d;
  logic [31:0]        ip_q, ip_d;
  logic [31:0]        crc_q, crc_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  function automatic logic [7:0] sel_byte(input logic [47:0] v, input int unsigned k);
    return 8'(v >> (8 * k));
  endfunction

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] frame_byte(
    input state_t      s,
    input int unsigned i,
    input logic        typ,
    input logic [47:0] mac,
    input logic [31:0] ip,
    input logic [31:0] crc
  );
    logic [7:0]  b;
    logic [31:0] fcs;
    b   = 8'h00;
    fcs = ~crc;
    case (s)
      S_PREAMBLE: b = (i == 7) ? 8'hD5 : 8'h55;
      S_ETH_HEAD: begin
        if (i < 6)       b = typ ? sel_byte(mac, 5 - i) : 8'hFF;
        else if (i < 12) b = sel_byte(BOARD_MAC, 11 - i);
        else             b = (i == 12) ? 8'h08 : 8'h06;
      end
      S_ARP_DATA: begin
        case (i)
          0:       b = 8'h00;
          1:       b = 8'h01;
          2:       b = 8'h08;
          3:       b = 8'h00;
          4:       b = 8'h06;
          5:       b = 8'h04;
          6:       b = 8'h00;
          7:       b = typ ? 8'h02 : 8'h01;
          default: begin
            if (i < 14)      b = sel_byte(BOARD_MAC, 13 - i);
            else if (i < 18) b = sel_byte({16'h0000, BOARD_IP}, 17 - i);
            else if (i < 24) b = typ ? sel_byte(mac, 23 - i) : 8'h00;
            else             b = sel_byte({16'h0000, ip}, 27 - i);
          end
        endcase
      end
      S_CRC:   b = sel_byte({16'h0000, fcs}, i);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_W'(cnt_q + 1'b1);
    type_d  = type_q;
    mac_d   = mac_q;
    ip_d    = ip_q;
    crc_d   = crc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (arp_tx_en) begin
          state_d = S_PREAMBLE;
          type_d  = arp_tx_type;
          mac_d   = des_mac;
          ip_d    = des_ip;
          busy_d  = 1'b1;
        end
      end
      S_PREAMBLE: begin
        crc_d = '1;
        if (cnt_q == CNT_W'(7)) begin
          state_d = S_ETH_HEAD;
          cnt_d   = '0;
        end
      end
      S_ETH_HEAD: begin
        crc_d = crc32_byte(crc_q, txd_q);
        if (cnt_q == CNT_W'(13)) begin
          state_d = S_ARP_DATA;
          cnt_d   = '0;
        end
      end
      S_ARP_DATA: begin
        crc_d = crc32_byte(crc_q, txd_q);
        if (cnt_q == CNT_W'(27)) begin
          state_d = S_PAD;
          cnt_d   = '0;
        end
      end
      S_PAD: begin
        crc_d = crc32_byte(crc_q, txd_q);
        if (cnt_q == CNT_W'(17)) begin
          state_d = S_CRC;
          cnt_d   = '0;
        end
      end
      S_CRC: begin
        if (cnt_q == CNT_W'(3)) begin
          state_d = S_GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        // GAP lasts IFG_CYCLES-1 cycles; the IDLE sampling cycle completes the idle gap.
        if ((32'(cnt_q) + 32'd2) >= IFG_CYCLES) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Outputs are registered, so the byte is looked up from the next state/count.
    tx_en_d = state_d inside {S_PREAMBLE, S_ETH_HEAD, S_ARP_DATA, S_PAD, S_CRC};
    txd_d   = tx_en_d ? frame_byte(state_d, 32'(cnt_d), type_d, mac_d, ip_d, crc_d) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= 1'b0;
      mac_q   <= '0;
      ip_q    <= '0;
      crc_q   <= '1;
      tx_en_q <= 1'b0;
      txd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      crc_q   <= crc_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
